// File: rtl/simd_div_arbiter.sv
// simd_div_arbiter: round-robin sharing of one serial SIMD divider.
// The owner holds the divider from operand issue until its result returns.
package simd_div_pkg;
  typedef enum logic [2:0] {
    VDIVU = 3'd0,
    VDIV  = 3'd1,
    VREMU = 3'd2,
    VREM  = 3'd3
  } ara_op_e;

  typedef enum logic [1:0] {
    EW8  = 2'd0,
    EW16 = 2'd1,
    EW32 = 2'd2,
    EW64 = 2'd3
  } vew_e;
endpackage

module simd_div_arbiter
  import simd_div_pkg::*;
#(
  parameter int unsigned NrReq = 4,
  parameter int unsigned DataWidth = 64,
  localparam int unsigned StrbWidth = DataWidth / 8,
  localparam int unsigned IdxWidth = $clog2(NrReq)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NrReq-1:0]                    req_valid_i,
  output logic [NrReq-1:0]                    req_ready_o,
  input  logic [NrReq-1:0][DataWidth-1:0]     req_opa_i,
  input  logic [NrReq-1:0][DataWidth-1:0]     req_opb_i,
  input  ara_op_e [NrReq-1:0]                 req_op_i,
  input  vew_e [NrReq-1:0]                    req_vew_i,
  input  logic [NrReq-1:0][StrbWidth-1:0]     req_be_i,
  input  logic [NrReq-1:0][StrbWidth-1:0]     req_mask_i,
  output logic [NrReq-1:0]                    res_valid_o,
  input  logic [NrReq-1:0]                    res_ready_i,
  output logic [DataWidth-1:0]                res_result_o,
  output logic [StrbWidth-1:0]                res_mask_o,
  output logic                                div_valid_o,
  input  logic                                div_ready_i,
  output logic [DataWidth-1:0]                div_opa_o,
  output logic [DataWidth-1:0]                div_opb_o,
  output ara_op_e                             div_op_o,
  output vew_e                                div_vew_o,
  output logic [StrbWidth-1:0]                div_be_o,
  output logic [StrbWidth-1:0]                div_mask_o,
  input  logic                                div_valid_i,
  output logic                                div_ready_o,
  input  logic [DataWidth-1:0]                div_result_i,
  input  logic [StrbWidth-1:0]                div_mask_i,
  output logic                                busy_o,
  output logic [IdxWidth-1:0]                 owner_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IdxWidth-1:0] owner_q, owner_d;
  logic [IdxWidth-1:0] rr_q, rr_d;
  logic [IdxWidth-1:0] pick;
  logic                pick_vld;
  int unsigned         idx;

  // first valid requester at or after rr_q, wrapping
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < NrReq; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NrReq) idx = idx - NrReq;
      if (!pick_vld && req_valid_i[IdxWidth'(idx)]) begin
        pick_vld = 1'b1;
        pick     = IdxWidth'(idx);
      end
    end
  end

  // next state, owner muxing and handshake steering
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    req_ready_o  = '0;
    res_valid_o  = '0;
    res_result_o = '0;
    res_mask_o   = '0;
    div_valid_o  = 1'b0;
    div_ready_o  = 1'b0;
    div_opa_o    = '0;
    div_opb_o    = '0;
    div_op_o     = VDIVU;
    div_vew_o    = EW8;
    div_be_o     = '0;
    div_mask_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        div_valid_o = 1'b1;
        div_opa_o   = req_opa_i[owner_q];
        div_opb_o   = req_opb_i[owner_q];
        div_op_o    = req_op_i[owner_q];
        div_vew_o   = req_vew_i[owner_q];
        div_be_o    = req_be_i[owner_q];
        div_mask_o  = req_mask_i[owner_q];
        if (div_ready_i) begin
          req_ready_o[owner_q] = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        res_valid_o[owner_q] = div_valid_i;
        div_ready_o  = res_ready_i[owner_q];
        res_result_o = div_result_i;
        res_mask_o   = div_mask_i;
        if (div_valid_i && res_ready_i[owner_q]) begin
          if (owner_q == IdxWidth'(NrReq - 1)) rr_d = '0;
          else rr_d = owner_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, owner and round-robin pointer registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign owner_o = busy_o ? owner_q : '0;

endmodule

// File: tb/tb_simd_div_arbiter.sv
// tb_simd_div_arbiter: random requesters and a model divider
// checked against a transaction-level round-robin reference.
module tb_simd_div_arbiter;
  import simd_div_pkg::*;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int IW = 2;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [N-1:0] req_valid_i, req_ready_o;
  logic [N-1:0][DW-1:0] req_opa_i, req_opb_i;
  ara_op_e [N-1:0] req_op_i;
  vew_e [N-1:0] req_vew_i;
  logic [N-1:0][SW-1:0] req_be_i, req_mask_i;
  logic [N-1:0] res_valid_o, res_ready_i;
  logic [DW-1:0] res_result_o;
  logic [SW-1:0] res_mask_o;
  logic div_valid_o, div_ready_i;
  logic [DW-1:0] div_opa_o, div_opb_o;
  ara_op_e div_op_o;
  vew_e div_vew_o;
  logic [SW-1:0] div_be_o, div_mask_o;
  logic div_valid_i, div_ready_o;
  logic [DW-1:0] div_result_i;
  logic [SW-1:0] div_mask_i;
  logic busy_o;
  logic [IW-1:0] owner_o;

  simd_div_arbiter #(.NrReq(N), .DataWidth(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_opa_i(req_opa_i), .req_opb_i(req_opb_i),
    .req_op_i(req_op_i), .req_vew_i(req_vew_i),
    .req_be_i(req_be_i), .req_mask_i(req_mask_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_result_o(res_result_o), .res_mask_o(res_mask_o),
    .div_valid_o(div_valid_o), .div_ready_i(div_ready_i),
    .div_opa_o(div_opa_o), .div_opb_o(div_opb_o),
    .div_op_o(div_op_o), .div_vew_o(div_vew_o),
    .div_be_o(div_be_o), .div_mask_o(div_mask_o),
    .div_valid_i(div_valid_i), .div_ready_o(div_ready_o),
    .div_result_i(div_result_i), .div_mask_i(div_mask_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clk_i = ~clk_i;

  int checks, errors;
  logic [N-1:0] pend, hold, exp_v;
  logic [63:0] exp_r [N];
  logic [7:0] exp_m [N];
  logic [63:0] last_res [N];
  logic [7:0] last_msk [N];
  int new_pct, rr_pct, drdy_pct, lat_max, fix_op, fix_vew;
  int m_own, m_ptr;
  bit m_iss;
  int dut_grants [$];
  bit dv_busy;
  int dv_cnt;
  logic [63:0] dv_res;
  logic [7:0] dv_msk;
  logic c_dv;
  logic [63:0] c_res;
  logic [IW-1:0] c_owner;
  logic [N-1:0] c_acc, c_rv;
  logic [7:0] c_be;
  ara_op_e c_op;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] simd_div(ara_op_e op, vew_e vew,
                                           logic [63:0] a, logic [63:0] b);
    int w;
    logic [63:0] m, r, ua, ub, q, rm;
    longint sa, sb, mn;
    w = 8 << int'(vew);
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    r = '0;
    for (int e = 0; e < 64 / w; e++) begin
      ua = (a >> (e * w)) & m;
      ub = (b >> (e * w)) & m;
      sa = $signed(ua << (64 - w)) >>> (64 - w);
      sb = $signed(ub << (64 - w)) >>> (64 - w);
      mn = -(longint'(1) <<< (w - 1));
      if (ub == 0) begin
        q = '1;
        rm = ua;
      end else if (op == VDIV || op == VREM) begin
        if (sa == mn && sb == -1) begin
          q = sa;
          rm = 0;
        end else begin
          q = sa / sb;
          rm = sa % sb;
        end
      end else begin
        q = ua / ub;
        rm = ua % ub;
      end
      r |= ((((op == VREMU) || (op == VREM)) ? rm : q) & m) << (e * w);
    end
    return r;
  endfunction

  function automatic int rr_pick(logic [N-1:0] v, int ptr);
    int best, bd;
    best = -1;
    bd = N;
    for (int i = 0; i < N; i++)
      if (v[i] && ((i - ptr + N) % N) < bd) begin
        bd = (i - ptr + N) % N;
        best = i;
      end
    return best;
  endfunction

  task automatic new_req(input int i, input ara_op_e op, input vew_e vw,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [7:0] be, input logic [7:0] msk);
    pend[i] = 1'b1;
    req_op_i[i] = op;
    req_vew_i[i] = vw;
    req_opa_i[i] = a;
    req_opb_i[i] = b;
    req_be_i[i] = be;
    req_mask_i[i] = msk;
    req_valid_i = pend;
  endtask

  task automatic rand_req(input int i);
    ara_op_e op;
    vew_e vw;
    op = (fix_op >= 0) ? ara_op_e'(3'(fix_op))
                       : ara_op_e'(3'($urandom_range(0, 3)));
    vw = (fix_vew >= 0) ? vew_e'(2'(fix_vew))
                        : vew_e'(2'($urandom_range(0, 3)));
    new_req(i, op, vw, {$urandom, $urandom}, {$urandom, $urandom},
            8'($urandom), 8'($urandom));
  endtask

  task automatic drive();
    div_valid_i = dv_busy && dv_cnt == 0;
    div_result_i = dv_busy ? dv_res : {$urandom, $urandom};
    div_mask_i = dv_busy ? dv_msk : 8'($urandom);
    div_ready_i = !dv_busy && ($urandom_range(0, 99) < drdy_pct);
    for (int i = 0; i < N; i++) begin
      res_ready_i[i] = !hold[i] && ($urandom_range(0, 99) < rr_pct);
      if (!pend[i]) begin
        if ($urandom_range(0, 99) < new_pct) rand_req(i);
        else begin
          req_opa_i[i] = {$urandom, $urandom};
          req_opb_i[i] = {$urandom, $urandom};
          req_be_i[i] = 8'($urandom);
          req_mask_i[i] = 8'($urandom);
        end
      end
    end
    req_valid_i = pend;
  endtask

  task automatic step();
    bit bz, is, wt, hs_iss, hs_res;
    logic [N-1:0] acc, rv, reqv;
    logic [63:0] res, c_opa, c_opb;
    logic [7:0] msk, c_mask;
    vew_e c_vew;
    @(negedge clk_i);
    bz = m_own >= 0;
    is = bz && !m_iss;
    wt = bz && m_iss;
    check("busy", busy_o, bz);
    check("owner", owner_o, bz ? m_own : 0);
    check("div_valid", div_valid_o, is);
    check("req_ready", req_ready_o,
          (is && div_ready_i) ? (64'd1 << m_own) : 0);
    check("div_opa", div_opa_o, is ? req_opa_i[m_own] : 0);
    check("div_opb", div_opb_o, is ? req_opb_i[m_own] : 0);
    check("div_op", div_op_o, is ? req_op_i[m_own] : 0);
    check("div_vew", div_vew_o, is ? req_vew_i[m_own] : 0);
    check("div_be", div_be_o, is ? req_be_i[m_own] : 0);
    check("div_mask", div_mask_o, is ? req_mask_i[m_own] : 0);
    check("res_valid", res_valid_o,
          (wt && div_valid_i) ? (64'd1 << m_own) : 0);
    check("div_ready", div_ready_o, wt ? res_ready_i[m_own] : 0);
    check("res_result", res_result_o, wt ? div_result_i : 0);
    check("res_mask", res_mask_o, wt ? div_mask_i : 0);
    if (is) check("own_valid", req_valid_i[m_own], 1);
    if (|req_ready_o) dut_grants.push_back(int'(owner_o));
    hs_iss = div_valid_o && div_ready_i;
    hs_res = div_valid_i && div_ready_o;
    acc = req_ready_o;
    rv = res_valid_o & res_ready_i;
    reqv = req_valid_i;
    res = res_result_o;
    msk = res_mask_o;
    c_opa = div_opa_o;
    c_opb = div_opb_o;
    c_mask = div_mask_o;
    c_vew = div_vew_o;
    c_op = div_op_o;
    c_be = div_be_o;
    c_dv = div_valid_o;
    c_res = res_result_o;
    c_owner = owner_o;
    c_acc = req_ready_o;
    c_rv = res_valid_o;
    @(posedge clk_i);
    if (m_own < 0) begin
      if (|reqv) begin
        m_own = rr_pick(reqv, m_ptr);
        m_iss = 1'b0;
      end
    end else if (!m_iss) begin
      if (div_ready_i) m_iss = 1'b1;
    end else if (div_valid_i && res_ready_i[m_own]) begin
      m_ptr = (m_own + 1) % N;
      m_own = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        check("dbl_accept", exp_v[i], 0);
        exp_v[i] = 1'b1;
        exp_r[i] = simd_div(req_op_i[i], req_vew_i[i],
                            req_opa_i[i], req_opb_i[i]);
        exp_m[i] = req_mask_i[i];
        pend[i] = 1'b0;
      end
      if (rv[i]) begin
        check("e2e_pending", exp_v[i], 1);
        check("e2e_res", res, exp_r[i]);
        check("e2e_mask", msk, exp_m[i]);
        exp_v[i] = 1'b0;
        last_res[i] = res;
        last_msk[i] = msk;
      end
    end
    if (hs_res) dv_busy = 1'b0;
    else if (dv_busy && dv_cnt > 0) dv_cnt--;
    if (hs_iss) begin
      dv_busy = 1'b1;
      dv_cnt = $urandom_range(0, lat_max);
      dv_res = simd_div(c_op, c_vew, c_opa, c_opb);
      dv_msk = c_mask;
    end
    #1 drive();
  endtask

  task automatic drain();
    int n;
    n = 0;
    new_pct = 0;
    hold = '0;
    rr_pct = 100;
    drdy_pct = 100;
    while ((m_own >= 0 || |pend || dv_busy || |exp_v) && n < 500) begin
      step();
      n++;
    end
    check("drain_timeout", n < 500, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;
    pend = '0;
    hold = '0;
    exp_v = '0;
    m_own = -1;
    m_iss = 1'b0;
    m_ptr = 0;
    dv_busy = 1'b0;
    dv_cnt = 0;
    dv_res = '0;
    dv_msk = '0;
    for (int i = 0; i < N; i++) begin
      last_res[i] = '0;
      last_msk[i] = '0;
      req_op_i[i] = VDIVU;
      req_vew_i[i] = EW8;
    end
    req_opa_i = '1;
    req_opb_i = '1;
    req_be_i = '1;
    req_mask_i = '1;
    rst_i = 1'b1;
    req_valid_i = '1;
    res_ready_i = '1;
    div_valid_i = 1'b1;
    div_ready_i = 1'b1;
    div_result_i = '1;
    div_mask_i = '1;
    rr_pct = 100;
    drdy_pct = 100;
    lat_max = 2;
    fix_op = -1;
    fix_vew = -1;
    new_pct = 0;
    @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_owner", owner_o, 0);
    check("rst_div_valid", div_valid_o, 0);
    check("rst_req_ready", req_ready_o, 0);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_div_ready", div_ready_o, 0);
    check("rst_res_result", res_result_o, 0);
    check("rst_div_opa", div_opa_o, 0);

    // all four requesting VDIV EW8 continuously
    fix_op = 1;
    fix_vew = 0;
    new_pct = 100;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    drive();
    dut_grants.delete();
    n = 0;
    while (dut_grants.size() < 5 && n < 300) begin
      step();
      n++;
    end
    check("fair_timeout", n < 300, 1);
    for (int i = 0; i < 5; i++)
      check($sformatf("fair_g%0d", i),
            (i < dut_grants.size()) ? dut_grants[i] : -1, i % N);
    drain();
    fix_op = -1;
    fix_vew = -1;

    // single request from 2: 100/7
    last_res[2] = '0;
    new_req(2, VDIVU, EW64, 64'd100, 64'd7, 8'hFF, 8'h3C);
    step();
    step();
    check("lat_div_valid", c_dv, 1);
    drain();
    check("single_res", last_res[2], 64'd14);

    // owner 1 stalls its result for 10 cycles
    lat_max = 0;
    hold[1] = 1'b1;
    new_req(1, VDIV, EW32, {$urandom, $urandom}, 64'h0000_0003_0000_0005,
            8'hFF, 8'h11);
    n = 0;
    while (!(m_own == 1 && m_iss && div_valid_i) && n < 50) begin
      step();
      n++;
    end
    check("hold_timeout", n < 50, 1);
    new_req(0, VDIVU, EW8, 64'h55, 64'h3, 8'h01, 8'h01);
    new_req(2, VDIVU, EW8, 64'h66, 64'h3, 8'h01, 8'h01);
    for (int k = 0; k < 10; k++) begin
      step();
      check("hold_res", c_res, dv_res);
      check("hold_owner", c_owner, 1);
      check("hold_rv", c_rv, 4'b0010);
      check("hold_noacc", c_acc, 0);
    end
    drain();
    lat_max = 2;

    // 3 hands back its result while 0 and 3 both request
    hold[3] = 1'b1;
    new_req(3, VREMU, EW64, 64'd50, 64'd9, 8'hFF, 8'h0F);
    n = 0;
    while (!(m_own == 3 && m_iss && div_valid_i) && n < 50) begin
      step();
      n++;
    end
    check("wrap_timeout", n < 50, 1);
    hold[3] = 1'b0;
    res_ready_i[3] = 1'b1;
    new_req(0, VDIVU, EW64, 64'd9, 64'd2, 8'hFF, 8'h01);
    new_req(3, VDIVU, EW64, 64'd8, 64'd2, 8'hFF, 8'h02);
    step();
    step();
    #1 check("wrap_owner", owner_o, 0);
    check("wrap_busy", busy_o, 1);
    drain();

    // be and mask pass through untouched
    new_req(1, VREM, EW16, 64'h1234_5678_9ABC_DEF0, 64'h0007_0005_0003_0011,
            8'h0F, 8'hA5);
    n = 0;
    c_dv = 1'b0;
    while (!c_dv && n < 20) begin
      step();
      n++;
    end
    check("be_timeout", n < 20, 1);
    check("be_fwd", c_be, 8'h0F);
    check("op_fwd", c_op, VREM);
    drain();
    check("mask_ret", last_msk[1], 8'hA5);

    // reset while 3 waits for its result
    hold[3] = 1'b1;
    new_req(3, VDIVU, EW64, 64'd77, 64'd7, 8'hFF, 8'h00);
    n = 0;
    while (!(m_own == 3 && m_iss) && n < 50) begin
      step();
      n++;
    end
    check("rst_wait_timeout", n < 50, 1);
    div_valid_i = 1'b1;
    res_ready_i = '1;
    #2 rst_i = 1'b1;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_owner", owner_o, 0);
    check("arst_res_valid", res_valid_o, 0);
    check("arst_div_ready", div_ready_o, 0);
    check("arst_div_valid", div_valid_o, 0);
    check("arst_res_result", res_result_o, 0);
    m_own = -1;
    m_iss = 1'b0;
    m_ptr = 0;
    pend = '0;
    hold = '0;
    exp_v = '0;
    dv_busy = 1'b0;
    drive();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    new_req(1, VDIVU, EW64, 64'd30, 64'd4, 8'hFF, 8'h00);
    new_req(2, VDIVU, EW64, 64'd40, 64'd4, 8'hFF, 8'h00);
    dut_grants.delete();
    n = 0;
    while (dut_grants.size() < 2 && n < 100) begin
      step();
      n++;
    end
    check("post_rst_timeout", n < 100, 1);
    check("post_rst_g0", (dut_grants.size() > 0) ? dut_grants[0] : -1, 1);
    check("post_rst_g1", (dut_grants.size() > 1) ? dut_grants[1] : -1, 2);
    drain();

    // random traffic
    new_pct = 20;
    rr_pct = 60;
    drdy_pct = 60;
    lat_max = 4;
    for (int k = 0; k < 2000; k++) begin
      if (k % 500 == 0) begin
        new_pct = $urandom_range(5, 60);
        rr_pct = $urandom_range(20, 100);
        drdy_pct = $urandom_range(20, 100);
      end
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
